// File: rtl/exu_cdb_arbiter.sv
// Dual-grant round-robin arbiter draining four one-entry EXU result buffers onto two registered CDB ports.
// Latency: transfer at edge N appears on CDB after edge N+1; req_rdy drops only while a buffer is full and ungranted, or on flush/reset.
module exu_cdb_arbiter #(
  parameter int PREG_W = 6,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_clk,
  input  logic                  rtu_global_flush,
  input  logic [3:0]            req_vld,
  input  logic [4*PREG_W-1:0]   req_preg,
  input  logic [4*DATA_W-1:0]   req_result,
  output logic [3:0]            req_rdy,
  output logic [1:0]            cdb_vld,
  output logic [2*PREG_W-1:0]   cdb_preg,
  output logic [2*DATA_W-1:0]   cdb_result,
  output logic                  arb_busy
);

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] result;
  } wb_t;

  wb_t        hold_dat [4];
  logic [3:0] hold_vld;
  logic [1:0] rr_ptr;

  logic [3:0] gnt;
  logic       g0_vld, g1_vld;
  logic [1:0] g0_idx, g1_idx;
  logic [1:0] scan_idx;
  logic [1:0] last_idx;
  logic       clr;
  logic [3:0] xfer;

  // Scan from rr_ptr: first occupied buffer goes to port 0, second to port 1.
  always_comb begin
    gnt      = '0;
    g0_vld   = 1'b0;
    g1_vld   = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_idx = '0;
    for (int j = 0; j < 4; j++) begin
      scan_idx = rr_ptr + 2'(j);
      if (hold_vld[scan_idx]) begin
        if (!g0_vld) begin
          g0_vld        = 1'b1;
          g0_idx        = scan_idx;
          gnt[scan_idx] = 1'b1;
        end else if (!g1_vld) begin
          g1_vld        = 1'b1;
          g1_idx        = scan_idx;
          gnt[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign clr      = rst_clk | rtu_global_flush;
  assign req_rdy  = {4{~clr}} & (~hold_vld | gnt);
  assign xfer     = req_vld & req_rdy;
  assign arb_busy = |hold_vld;
  assign last_idx = g1_vld ? g1_idx : g0_idx;

  always_ff @(posedge clk) begin
    if (clr) begin
      hold_vld   <= '0;
      rr_ptr     <= '0;
      cdb_vld    <= '0;
      cdb_preg   <= '0;
      cdb_result <= '0;
    end else begin
      // A new transfer into a buffer being granted this cycle keeps it occupied.
      hold_vld <= xfer | (hold_vld & ~gnt);
      cdb_vld  <= {g1_vld, g0_vld};
      cdb_preg[0 +: PREG_W]        <= g0_vld ? hold_dat[g0_idx].preg   : '0;
      cdb_result[0 +: DATA_W]      <= g0_vld ? hold_dat[g0_idx].result : '0;
      cdb_preg[PREG_W +: PREG_W]   <= g1_vld ? hold_dat[g1_idx].preg   : '0;
      cdb_result[DATA_W +: DATA_W] <= g1_vld ? hold_dat[g1_idx].result : '0;
      if (g0_vld) rr_ptr <= last_idx + 2'd1;
    end
  end

  // Payload needs no reset: it is only observed while hold_vld is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (xfer[i]) begin
        hold_dat[i].preg   <= req_preg[i*PREG_W +: PREG_W];
        hold_dat[i].result <= req_result[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule
